// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg -- shared types and constants for the write-back stage.
//   XLEN / VLEN / VLANES : scalar width, vector width, lanes per vector
//   wb_sel_e             : result-select encoding carried by WB_MemToReg
//   va_state_e           : vector assembler FSM states
//   wb_select()          : result mux (reserved code falls back to the ALU)
// -----------------------------------------------------------------------------
package wb_pkg;

    localparam int XLEN   = 32;
    localparam int VLEN   = 128;
    localparam int VLANES = 4;

    typedef enum logic [1:0] {
        SEL_ALU  = 2'b00,
        SEL_MEM  = 2'b01,
        SEL_SBOX = 2'b10,
        SEL_RSVD = 2'b11
    } wb_sel_e;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } va_state_e;

    function automatic logic [XLEN-1:0] wb_select(
        input wb_sel_e         sel,
        input logic [XLEN-1:0] alu,
        input logic [XLEN-1:0] mem,
        input logic [XLEN-1:0] sbox
    );
        logic [XLEN-1:0] res;
        case (sel)
            SEL_MEM:  res = mem;
            SEL_SBOX: res = sbox;
            default:  res = alu;    // SEL_ALU and the reserved code
        endcase
        return res;
    endfunction

endpackage

// File: rtl/wb_stage_if.sv
// -----------------------------------------------------------------------------
// wb_stage_if -- MEM/WB pipeline-register bundle feeding the write-back stage.
//   WB_MemData / WB_ALUResult / WB_sbox : candidate results (XLEN each)
//   WB_rd                               : destination register (scalar or vector)
//   WB_MemToReg                         : result select (wb_sel_e encoding)
//   WB_RegWrite / WB_VRegWrite          : scalar / vector-lane write requests
// Modports: master drives the bundle (MEM/WB register), slave consumes it.
// -----------------------------------------------------------------------------
interface wb_stage_if;
    import wb_pkg::*;

    logic [XLEN-1:0] WB_MemData;
    logic [XLEN-1:0] WB_ALUResult;
    logic [XLEN-1:0] WB_sbox;
    logic [4:0]      WB_rd;
    logic [1:0]      WB_MemToReg;
    logic            WB_RegWrite;
    logic            WB_VRegWrite;

    modport master (
        output WB_MemData, WB_ALUResult, WB_sbox, WB_rd,
               WB_MemToReg, WB_RegWrite, WB_VRegWrite
    );

    modport slave (
        input  WB_MemData, WB_ALUResult, WB_sbox, WB_rd,
               WB_MemToReg, WB_RegWrite, WB_VRegWrite
    );

endinterface

// File: rtl/wb_vec_assembler.sv
// -----------------------------------------------------------------------------
// wb_vec_assembler -- gathers four consecutive lane words into one vector write.
//   clk, rst_n      : clock, asynchronous active-low reset
//   vwe_i           : lane word valid this cycle
//   rd_i            : destination vector register of the lane word
//   wdata_i         : lane word
//   vrf_we_o        : one-cycle vector write strobe (cycle after lane 3)
//   vrf_waddr_o     : latched destination register, valid with vrf_we_o
//   vrf_wdata_o     : assembled vector while vrf_we_o is high, else 0
//   vec_abort_o     : one-cycle pulse when a partial vector is discarded
// A word for a different rd during FILL abandons the partial vector and
// starts over with that word as lane 0. Cycles without a word hold state.
// -----------------------------------------------------------------------------
module wb_vec_assembler
    import wb_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            vwe_i,
    input  logic [4:0]      rd_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic            vrf_we_o,
    output logic [4:0]      vrf_waddr_o,
    output logic [VLEN-1:0] vrf_wdata_o,
    output logic            vec_abort_o
);

    va_state_e                   state_q;
    logic [1:0]                  cnt_q;
    logic [4:0]                  rd_q;
    logic [VLANES-1:0][XLEN-1:0] lane_q;
    logic                        vrf_we_q;
    logic [4:0]                  vrf_waddr_q;
    logic                        vec_abort_q;

    // NOTE: non-blocking (<=) for every register so all flops update from
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rd_q        <= '0;
            // NOTE: the lane buffer is reset too, so a vector cut short by
            // reset can never leak stale lanes into a later write.
            lane_q      <= '0;
            vrf_we_q    <= 1'b0;
            vrf_waddr_q <= '0;
            vec_abort_q <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            vrf_we_q    <= 1'b0;
            vec_abort_q <= 1'b0;
            if (vwe_i) begin
                case (state_q)
                    IDLE: begin
                        lane_q[0] <= wdata_i;
                        rd_q      <= rd_i;
                        cnt_q     <= 2'd1;
                        state_q   <= FILL;
                    end
                    FILL: begin
                        if (rd_i != rd_q) begin
                            vec_abort_q <= 1'b1;
                            lane_q[0]   <= wdata_i;
                            rd_q        <= rd_i;
                            cnt_q       <= 2'd1;
                        end else begin
                            lane_q[cnt_q] <= wdata_i;
                            cnt_q         <= cnt_q + 2'd1;   // lane 3 wraps to 0
                            if (cnt_q == 2'd3) begin
                                vrf_we_q    <= 1'b1;
                                vrf_waddr_q <= rd_q;
                                state_q     <= IDLE;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign vrf_we_o    = vrf_we_q;
    assign vrf_waddr_o = vrf_waddr_q;
    assign vrf_wdata_o = vrf_we_q ? lane_q : '0;
    assign vec_abort_o = vec_abort_q;

endmodule

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage -- pipeline write-back stage (scalar + vector register files).
//   clk, rst_n                     : clock, asynchronous active-low reset
//   wb (wb_stage_if.slave)         : MEM/WB register bundle
//   rf_we / rf_waddr / rf_wdata    : registered scalar RF write port
//   vrf_we / vrf_waddr / vrf_wdata : vector RF write port (from assembler)
//   vec_abort                      : partial vector discarded
//   fwd_valid / fwd_rd / fwd_data  : combinational forwarding to hazard unit
// Build option: define WB_FWD_EN to enable forwarding; otherwise the fwd_*
// ports remain but are tied to 0.
// -----------------------------------------------------------------------------
module wb_stage
    import wb_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    wb_stage_if.slave       wb,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            vrf_we,
    output logic [4:0]      vrf_waddr,
    output logic [VLEN-1:0] vrf_wdata,
    output logic            vec_abort,
    output logic            fwd_valid,
    output logic [4:0]      fwd_rd,
    output logic [XLEN-1:0] fwd_data
);

    logic [XLEN-1:0] result;
    logic            rf_we_d, rf_we_q;
    logic [4:0]      rf_waddr_d, rf_waddr_q;
    logic [XLEN-1:0] rf_wdata_d, rf_wdata_q;

    assign result = wb_select(wb_sel_e'(wb.WB_MemToReg), wb.WB_ALUResult,
                              wb.WB_MemData, wb.WB_sbox);

    // Writes to x0 are dropped here so the register file never sees them.
    // NOTE: every always_comb output gets a value on every path (defaults
    // first), otherwise synthesis infers a latch.
    always_comb begin
        rf_we_d    = wb.WB_RegWrite && (wb.WB_rd != 5'd0);
        rf_waddr_d = '0;
        rf_wdata_d = '0;
        if (rf_we_d) begin
            rf_waddr_d = wb.WB_rd;
            rf_wdata_d = result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

    wb_vec_assembler u_vec_asm (
        .clk         (clk),
        .rst_n       (rst_n),
        .vwe_i       (wb.WB_VRegWrite),
        .rd_i        (wb.WB_rd),
        .wdata_i     (result),
        .vrf_we_o    (vrf_we),
        .vrf_waddr_o (vrf_waddr),
        .vrf_wdata_o (vrf_wdata),
        .vec_abort_o (vec_abort)
    );

`ifdef WB_FWD_EN
    assign fwd_valid = rf_we_d;
    assign fwd_rd    = wb.WB_rd;
    assign fwd_data  = result;
`else
    assign fwd_valid = 1'b0;
    assign fwd_rd    = '0;
    assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_stage -- directed self-checking bench for wb_stage.
// Inputs change 1 ns after a rising edge; registered outputs are sampled there
// too, combinational forwarding is sampled before the edge.
// -----------------------------------------------------------------------------
module tb_wb_stage;
    import wb_pkg::*;

    logic            clk;
    logic            rst_n;
    logic            rf_we, vrf_we, vec_abort, fwd_valid;
    logic [4:0]      rf_waddr, vrf_waddr, fwd_rd;
    logic [31:0]     rf_wdata, fwd_data;
    logic [127:0]    vrf_wdata;

    int total = 0;
    int bad   = 0;

    wb_stage_if wb_bus ();

    wb_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wb        (wb_bus.slave),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .vrf_we    (vrf_we),
        .vrf_waddr (vrf_waddr),
        .vrf_wdata (vrf_wdata),
        .vec_abort (vec_abort),
        .fwd_valid (fwd_valid),
        .fwd_rd    (fwd_rd),
        .fwd_data  (fwd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] observed,
                         input logic [127:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic drive(input logic regw, input logic vregw, input logic [1:0] sel,
                         input logic [4:0] rd, input logic [31:0] mem,
                         input logic [31:0] alu, input logic [31:0] sbox);
        wb_bus.WB_RegWrite  = regw;
        wb_bus.WB_VRegWrite = vregw;
        wb_bus.WB_MemToReg  = sel;
        wb_bus.WB_rd        = rd;
        wb_bus.WB_MemData   = mem;
        wb_bus.WB_ALUResult = alu;
        wb_bus.WB_sbox      = sbox;
    endtask

    task automatic bubble();
        drive(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Vector lane word through the sbox path.
    task automatic vword(input logic [4:0] rd, input logic [31:0] w);
        drive(1'b0, 1'b1, 2'b10, rd, 32'hBAD0_0001, 32'hBAD0_0002, w);
    endtask

    task automatic check_fwd(input string tag, input logic v, input logic [4:0] rd,
                             input logic [31:0] d);
`ifdef WB_FWD_EN
        check({tag, "_valid"}, fwd_valid, v);
        check({tag, "_rd"},    fwd_rd,    rd);
        check({tag, "_data"},  fwd_data,  d);
`else
        check({tag, "_valid"}, fwd_valid, 1'b0);
        check({tag, "_rd"},    fwd_rd,    5'd0);
        check({tag, "_data"},  fwd_data,  32'd0);
`endif
    endtask

    initial begin
        // ---------------- reset state ----------------
        rst_n = 1'b0;
        bubble();
        repeat (2) tick();
        check("rst_rf_we",     rf_we,     1'b0);
        check("rst_rf_waddr",  rf_waddr,  5'd0);
        check("rst_rf_wdata",  rf_wdata,  32'd0);
        check("rst_vrf_we",    vrf_we,    1'b0);
        check("rst_vrf_waddr", vrf_waddr, 5'd0);
        check("rst_vrf_wdata", vrf_wdata, 128'd0);
        check("rst_abort",     vec_abort, 1'b0);
        check_fwd("rst_fwd", 1'b0, 5'd0, 32'd0);

        // Release away from the edge; first input is taken on the next edge.
        rst_n = 1'b1;

        // ---------------- scalar write, Mem select ----------------
        drive(1'b1, 1'b0, 2'b01, 5'd5, 32'hDEADBEEF, 32'h1111_1111, 32'h2222_2222);
        #1 check_fwd("fwd_mem", 1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        check("mem_rf_we",    rf_we,    1'b1);
        check("mem_rf_waddr", rf_waddr, 5'd5);
        check("mem_rf_wdata", rf_wdata, 32'hDEADBEEF);

        // ALU, sbox and reserved selects
        drive(1'b1, 1'b0, 2'b00, 5'd6, 32'h1111_1111, 32'h0000_A5A5, 32'h2222_2222);
        tick();
        check("alu_rf_waddr", rf_waddr, 5'd6);
        check("alu_rf_wdata", rf_wdata, 32'h0000_A5A5);
        drive(1'b1, 1'b0, 2'b10, 5'd31, 32'h1111_1111, 32'h3333_3333, 32'h5A5A_0F0F);
        tick();
        check("sbox_rf_waddr", rf_waddr, 5'd31);
        check("sbox_rf_wdata", rf_wdata, 32'h5A5A_0F0F);
        drive(1'b1, 1'b0, 2'b11, 5'd8, 32'h1111_1111, 32'hCAFE_F00D, 32'h2222_2222);
        tick();
        check("rsvd_rf_wdata", rf_wdata, 32'hCAFE_F00D);

        bubble();
        tick();
        check("idle_rf_we", rf_we, 1'b0);

        // ---------------- x0 guard ----------------
        drive(1'b1, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0000_1234, 32'h0);
        #1 check("x0_fwd_valid", fwd_valid, 1'b0);
        tick();
        check("x0_rf_we", rf_we, 1'b0);

        // ---------------- vector fill with a bubble after lane 1 ----------------
        vword(5'd3, 32'h00112233); tick();
        check("fill0_vrf_we", vrf_we, 1'b0);
        check("fill0_rf_we",  rf_we,  1'b0);
        vword(5'd3, 32'h44556677); tick();
        check("fill1_vrf_we", vrf_we, 1'b0);
        bubble();                  tick();
        check("fillb_vrf_we", vrf_we, 1'b0);
        vword(5'd3, 32'h8899AABB); tick();
        check("fill2_vrf_we", vrf_we, 1'b0);
        vword(5'd3, 32'hCCDDEEFF); tick();
        check("fill3_vrf_we",    vrf_we,    1'b1);
        check("fill3_vrf_waddr", vrf_waddr, 5'd3);
        check("fill3_vrf_wdata", vrf_wdata, 128'hCCDDEEFF_8899AABB_44556677_00112233);
        check("fill3_abort",     vec_abort, 1'b0);
        bubble(); tick();
        check("fill_post_vrf_we",    vrf_we,    1'b0);
        check("fill_post_vrf_wdata", vrf_wdata, 128'd0);

        // ---------------- abort on rd change ----------------
        vword(5'd3, 32'hA0A0_0000); tick();
        vword(5'd3, 32'hA1A1_0001); tick();
        check("ab_pre_abort", vec_abort, 1'b0);
        vword(5'd4, 32'h4000_0000); tick();
        check("ab_abort",  vec_abort, 1'b1);
        check("ab_vrf_we", vrf_we,    1'b0);
        vword(5'd4, 32'h4000_0001); tick();
        check("ab_abort_pulse", vec_abort, 1'b0);
        check("ab1_vrf_we",     vrf_we,    1'b0);
        vword(5'd4, 32'h4000_0002); tick();
        check("ab2_vrf_we", vrf_we, 1'b0);
        vword(5'd4, 32'h4000_0003); tick();
        check("ab3_vrf_we",    vrf_we,    1'b1);
        check("ab3_vrf_waddr", vrf_waddr, 5'd4);
        check("ab3_vrf_wdata", vrf_wdata, 128'h40000003_40000002_40000001_40000000);
        // Fourth extra word starts a new vector: no second write.
        vword(5'd4, 32'h4000_0004); tick();
        check("ab4_vrf_we", vrf_we,    1'b0);
        check("ab4_abort",  vec_abort, 1'b0);

        // ---------------- reset mid-fill ----------------
        // Second lane of the rd=4 partial, with a scalar write riding along
        // so an output is high when reset hits.
        drive(1'b1, 1'b1, 2'b10, 5'd4, 32'h0, 32'h0, 32'h4000_0005);
        tick();
        check("mid_rf_we_pre", rf_we, 1'b1);
        bubble();
        #1 rst_n = 1'b0;
        #1;
        check("mid_async_rf_we",    rf_we,     1'b0);
        check("mid_async_rf_waddr", rf_waddr,  5'd0);
        check("mid_async_rf_wdata", rf_wdata,  32'd0);
        check("mid_async_vrf_we",   vrf_we,    1'b0);
        check("mid_async_abort",    vec_abort, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        vword(5'd10, 32'h1000_0000); tick();
        check("rs0_abort",  vec_abort, 1'b0);
        check("rs0_vrf_we", vrf_we,    1'b0);
        vword(5'd10, 32'h1000_0001); tick();
        check("rs1_abort",  vec_abort, 1'b0);
        vword(5'd10, 32'h1000_0002); tick();
        check("rs2_vrf_we", vrf_we, 1'b0);
        vword(5'd10, 32'h1000_0003); tick();
        check("rs3_vrf_we",    vrf_we,    1'b1);
        check("rs3_vrf_waddr", vrf_waddr, 5'd10);
        check("rs3_vrf_wdata", vrf_wdata, 128'h10000003_10000002_10000001_10000000);
        check("rs3_abort",     vec_abort, 1'b0);

        // ---------------- simultaneous scalar + vector lane 3 ----------------
        drive(1'b0, 1'b1, 2'b00, 5'd7, 32'h0, 32'h7000_0000, 32'h0); tick();
        drive(1'b0, 1'b1, 2'b00, 5'd7, 32'h0, 32'h7000_0001, 32'h0); tick();
        drive(1'b0, 1'b1, 2'b00, 5'd7, 32'h0, 32'h7000_0002, 32'h0); tick();
        drive(1'b1, 1'b1, 2'b00, 5'd7, 32'h0, 32'h7000_0003, 32'h0); tick();
        check("sim_rf_we",     rf_we,     1'b1);
        check("sim_rf_waddr",  rf_waddr,  5'd7);
        check("sim_rf_wdata",  rf_wdata,  32'h7000_0003);
        check("sim_vrf_we",    vrf_we,    1'b1);
        check("sim_vrf_waddr", vrf_waddr, 5'd7);
        check("sim_vrf_wdata", vrf_wdata, 128'h70000003_70000002_70000001_70000000);
        bubble(); tick();
        check("sim_post_rf_we",  rf_we,  1'b0);
        check("sim_post_vrf_we", vrf_we, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have ports: clk  in  1  pipeline clock, rising edge.
REQ-002 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: WB_MemData  in  32  load data from the MEM/WB register.
REQ-004 SHALL have ports: WB_ALUResult  in  32  ALU result from the MEM/WB register.
REQ-005 SHALL have ports: WB_sbox  in  32  S-box lookup result from the MEM/WB register.
REQ-006 SHALL have ports: WB_rd  in  5  destination register index (scalar or vector).
REQ-007 SHALL have ports: WB_MemToReg  in  2  result select; 00 ALU, 01 Mem, 10 sbox, 11 reserved.
REQ-008 SHALL have ports: WB_RegWrite  in  1  scalar write request; WB_VRegWrite  in  1  vector lane write request.
REQ-009 SHALL have ports: rf_we  out  1, rf_waddr  out  5, rf_wdata  out  32  scalar register-file write port.
REQ-010 SHALL have ports: vrf_we  out  1, vrf_waddr  out  5, vrf_wdata  out  128  vector register-file write port.
REQ-011 SHALL have ports: vec_abort  out  1  one-cycle pulse when a partial vector is discarded.
REQ-012 SHALL have ports: fwd_valid  out  1, fwd_rd  out  5, fwd_data  out  32  forwarding to the hazard unit.

Function
REQ-013 SHALL compute the result combinationally: ALUResult for 00 and 11, MemData for 01, sbox for 10.
REQ-014 SHALL register the scalar write: rf_we/rf_waddr/rf_wdata valid exactly one cycle after WB_RegWrite is sampled high.
REQ-015 SHALL suppress the scalar write when WB_rd == 0; rf_we stays 0.
REQ-016 SHALL assemble a vector from four consecutive WB_VRegWrite words: lane 0 = vrf_wdata[31:0] ... lane 3 = [127:96].
REQ-017 SHALL implement the assembler FSM with states IDLE and FILL, plus a 2-bit lane counter.
REQ-018 SHALL transition IDLE->FILL on a VRegWrite word; it stores lane 0, latches rd, and sets the counter to 1.
REQ-019 SHALL, in FILL with a VRegWrite word and the same rd, store that word at the counter lane and increment the counter.
REQ-020 SHALL, on storing lane 3, pulse vrf_we for one cycle on the next cycle, with vrf_waddr = the latched rd, then return to IDLE (counter wraps to 0).
REQ-021 SHALL, in FILL with a VRegWrite word whose rd differs, pulse vec_abort, discard the partial vector, and restart at lane 0 with the new word and rd.
REQ-022 SHALL hold state on cycles without VRegWrite; bubbles between lanes are legal.
REQ-023 SHALL process WB_RegWrite and WB_VRegWrite independently when both are high in one cycle.
REQ-024 SHALL drive vrf_wdata as the assembled value only while vrf_we is high; otherwise it is 0.

Reset
REQ-025 SHALL, on rst_n low, immediately force IDLE, counter 0, lane buffer 0, and all outputs to 0.
REQ-026 SHALL drop a vector partially assembled at reset without writing it and without pulsing vec_abort.
REQ-027 SHALL accept the first input on the first rising clk after rst_n deasserts.

Configuration
REQ-028 SHALL compile the forwarding port only when WB_FWD_EN is defined.
REQ-029 SHALL, with WB_FWD_EN: drive fwd_valid = WB_RegWrite && WB_rd != 0 combinationally, with fwd_rd = WB_rd and fwd_data = the selected result.
REQ-030 SHALL, without WB_FWD_EN: keep the fwd_* ports present and tie them to 0.

Structure
REQ-031 SHALL place the result-select enum (SEL_ALU, SEL_MEM, SEL_SBOX, SEL_RSVD), VLANES = 4, XLEN = 32, and VLEN = 128 in package wb_pkg.
REQ-032 SHALL implement the FSM, counter, and lane buffer in the sub-module wb_vec_assembler; the top level contains only the mux and the scalar register.

Verification
REQ-033 Scalar write: MemToReg=01, MemData=0xDEADBEEF, rd=5, RegWrite=1 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
REQ-034 x0 guard: RegWrite=1, rd=0, ALU=0x1234 -> rf_we stays 0; fwd_valid=0 with WB_FWD_EN.
REQ-035 Vector fill: sbox words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF, rd=3, one bubble after lane 1 -> vrf_we one cycle with vrf_wdata=0xCCDDEEFF_8899AABB_44556677_00112233 and vrf_waddr=3.
REQ-036 Abort: two words to rd=3, then a word to rd=4 -> vec_abort pulse; four more words to rd=4 give only one vrf_we, with vrf_waddr=4.
REQ-037 Reset mid-fill: two lanes sent, rst_n low mid-cycle -> outputs 0 asynchronously; next four words produce a clean vector with no abort.
REQ-038 Simultaneous: RegWrite=1 rd=7 and VRegWrite=1 on lane 3 in the same cycle -> rf_we and vrf_we both high on the next cycle.
